// File: rtl/aqed_batch_monitor_pkg.sv
// Shared types for the A-QED batch monitor: pairing FSM states and default widths.
// Optional embedded properties are enabled with `AQED_MON_SVA_EN.
package aqed_mon_pkg;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_NUM_CH  = 1;
  localparam int DEF_DEPTH_W = 16;
  localparam int DEF_WORD_W  = DEF_DATA_W * DEF_NUM_CH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ORIG = 2'd1,
    S_DUP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  typedef logic [DEF_WORD_W-1:0]  data_t;
  typedef logic [DEF_DEPTH_W-1:0] idx_t;
endpackage

// File: rtl/aqed_batch_monitor_if.sv
// Traffic and status bundle between a memory core harness and the A-QED batch monitor.
// master drives core traffic into the monitor; slave is the monitor side.
interface aqed_mon_if #(
  parameter int DATA_W  = 16,
  parameter int NUM_CH  = 1,
  parameter int DEPTH_W = 16
);
  localparam int WORD_W = DATA_W * NUM_CH;

  logic               clk_en;
  logic [DEPTH_W-1:0] depth;
  logic               wen_in;
  logic               ren_in;
  logic [WORD_W-1:0]  data_in;
  logic               valid_out;
  logic [WORD_W-1:0]  data_out;
  logic               orig_sel;
  logic               dup_sel;
  logic               wen_allow;
  logic               ren_allow;
  logic               batch_done;
  logic               qed_done;
  logic               qed_check;

  modport master (
    output clk_en, depth, wen_in, ren_in, data_in, valid_out, data_out, orig_sel, dup_sel,
    input  wen_allow, ren_allow, batch_done, qed_done, qed_check
  );

  modport slave (
    input  clk_en, depth, wen_in, ren_in, data_in, valid_out, data_out, orig_sel, dup_sel,
    output wen_allow, ren_allow, batch_done, qed_done, qed_check
  );
endinterface

// File: rtl/aqed_batch_monitor_counter.sv
// Per-batch event counter: counts accepted events, reports whether the current
// or incremented value has reached the batch limit.
module aqed_batch_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  input  logic [W-1:0] limit,
  output logic [W-1:0] cnt,
  output logic         at_limit,
  output logic         next_at_limit
);
  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign cnt_d         = cnt_q + {{(W-1){1'b0}}, inc};
  assign cnt           = cnt_q;
  assign at_limit      = (cnt_q == limit);
  assign next_at_limit = (cnt_d == limit);

  // counter register, cleared on reset or batch boundary
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/aqed_batch_monitor.sv
// A-QED consistency monitor: batch bound generation plus original/duplicate write pairing.
// Define AQED_MON_SVA_EN to embed the formal assumptions and assertions.
module aqed_batch_monitor
  import aqed_mon_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int DEPTH_W = DEF_DEPTH_W
) (
  input logic        clk,
  input logic        reset,
  aqed_mon_if.slave  mon
);
  localparam int WORD_W = DATA_W * NUM_CH;

  logic [DEPTH_W-1:0] depth_q;
  logic [DEPTH_W-1:0] wr_cnt, rd_cnt, rsp_cnt;
  logic               wr_at, rd_at, rsp_at;
  logic               wr_nxt, rd_nxt, rsp_nxt;
  logic               wr_acc, rd_acc, rsp_acc, boundary;
  logic               batch_done_q;

  state_t             state_q, state_d;
  logic [DEPTH_W-1:0] orig_idx_q, orig_idx_d, dup_idx_q, dup_idx_d;
  logic [WORD_W-1:0]  orig_data_q, orig_data_d;
  logic [WORD_W-1:0]  orig_out_q, orig_out_d, dup_out_q, dup_out_d;
  logic               qed_done_q;
  logic               rsp_hit_orig, rsp_hit_dup, rsp_hit_wr, dup_match;

  assign wr_acc  = mon.clk_en & mon.wen_in    & ~wr_at;
  assign rd_acc  = mon.clk_en & mon.ren_in    & ~rd_at;
  assign rsp_acc = mon.clk_en & mon.valid_out & ~rsp_at;
  // depth 0 would make every "next == depth" test true with no traffic; it keeps the monitor idle
  assign boundary = mon.clk_en & (depth_q != {DEPTH_W{1'b0}}) & wr_nxt & rd_nxt & rsp_nxt;

  aqed_batch_counter #(.W(DEPTH_W)) u_wr_cnt (
    .clk(clk), .reset(reset), .inc(wr_acc), .clr(boundary), .limit(depth_q),
    .cnt(wr_cnt), .at_limit(wr_at), .next_at_limit(wr_nxt)
  );
  aqed_batch_counter #(.W(DEPTH_W)) u_rd_cnt (
    .clk(clk), .reset(reset), .inc(rd_acc), .clr(boundary), .limit(depth_q),
    .cnt(rd_cnt), .at_limit(rd_at), .next_at_limit(rd_nxt)
  );
  aqed_batch_counter #(.W(DEPTH_W)) u_rsp_cnt (
    .clk(clk), .reset(reset), .inc(rsp_acc), .clr(boundary), .limit(depth_q),
    .cnt(rsp_cnt), .at_limit(rsp_at), .next_at_limit(rsp_nxt)
  );

  // batch depth and boundary pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      depth_q      <= mon.depth;
      batch_done_q <= 1'b0;
    end else begin
      depth_q      <= boundary ? mon.depth : depth_q;
      batch_done_q <= boundary;
    end
  end

  assign rsp_hit_orig = rsp_acc & (rsp_cnt == orig_idx_q);
  assign rsp_hit_dup  = rsp_acc & (rsp_cnt == dup_idx_q);
  assign rsp_hit_wr   = rsp_acc & (rsp_cnt == wr_cnt);
  assign dup_match    = wr_acc & mon.dup_sel & (mon.data_in == orig_data_q);

  // pairing next-state: the write being tagged may have its response in the same cycle
  always_comb begin
    state_d     = state_q;
    orig_idx_d  = orig_idx_q;
    dup_idx_d   = dup_idx_q;
    orig_data_d = orig_data_q;
    orig_out_d  = orig_out_q;
    dup_out_d   = dup_out_q;
    case (state_q)
      S_IDLE: begin
        if (wr_acc && mon.orig_sel) begin
          state_d     = S_ORIG;
          orig_idx_d  = wr_cnt;
          orig_data_d = mon.data_in;
          orig_out_d  = rsp_hit_wr ? mon.data_out : orig_out_q;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ORIG: begin
        orig_out_d = rsp_hit_orig ? mon.data_out : orig_out_q;
        if (dup_match) begin
          dup_idx_d = wr_cnt;
          dup_out_d = rsp_hit_wr ? mon.data_out : dup_out_q;
          state_d   = rsp_hit_wr ? S_DONE : S_DUP;
        end else begin
          state_d = S_ORIG;
        end
      end
      S_DUP: begin
        orig_out_d = rsp_hit_orig ? mon.data_out : orig_out_q;
        if (rsp_hit_dup) begin
          dup_out_d = mon.data_out;
          state_d   = S_DONE;
        end else begin
          state_d = S_DUP;
        end
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
    // a pair completing on the final response of the batch still counts
    if (boundary && (state_d != S_DONE)) begin
      state_d = S_IDLE;
    end else begin
      state_d = state_d;
    end
  end

  // pairing state and captured data
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      orig_idx_q  <= {DEPTH_W{1'b0}};
      dup_idx_q   <= {DEPTH_W{1'b0}};
      orig_data_q <= {WORD_W{1'b0}};
      orig_out_q  <= {WORD_W{1'b0}};
      dup_out_q   <= {WORD_W{1'b0}};
      qed_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      orig_idx_q  <= orig_idx_d;
      dup_idx_q   <= dup_idx_d;
      orig_data_q <= orig_data_d;
      orig_out_q  <= orig_out_d;
      dup_out_q   <= dup_out_d;
      qed_done_q  <= (state_d == S_DONE);
    end
  end

  assign mon.wen_allow  = ~wr_at;
  assign mon.ren_allow  = ~rd_at;
  assign mon.batch_done = batch_done_q;
  assign mon.qed_done   = qed_done_q;
  assign mon.qed_check  = ~qed_done_q | (orig_out_q == dup_out_q);

`ifdef AQED_MON_SVA_EN
  asm_wen_allowed: assume property (@(posedge clk) disable iff (reset) mon.wen_in |-> mon.wen_allow);
  asm_ren_allowed: assume property (@(posedge clk) disable iff (reset) mon.ren_in |-> mon.ren_allow);
  asm_depth_stable: assume property (@(posedge clk) disable iff (reset) !boundary |-> (mon.depth == depth_q));
  ast_qed_ok: assert property (@(posedge clk) disable iff (reset) mon.qed_done |-> mon.qed_check);
  ast_cnt_order: assert property (@(posedge clk) disable iff (reset) (rsp_cnt <= rd_cnt) && (rd_cnt <= depth_q));
`endif
endmodule

// File: tb/tb_aqed_batch_monitor.sv
// Self-checking bench for aqed_batch_monitor: directed batch/pairing scenarios, then random traffic
// compared each cycle against a behavioural model of batches and the original/duplicate pair.
module tb_aqed_batch_monitor;
  localparam int DW = 16;
  localparam int NC = 1;
  localparam int PW = 16;
  localparam int WW = DW * NC;

  logic clk = 1'b0;
  logic reset;

  aqed_mon_if #(.DATA_W(DW), .NUM_CH(NC), .DEPTH_W(PW)) mon_if ();

  aqed_batch_monitor #(.DATA_W(DW), .NUM_CH(NC), .DEPTH_W(PW)) dut (
    .clk   (clk),
    .reset (reset),
    .mon   (mon_if)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // global drive knobs
  bit g_rst = 1'b0;
  bit g_ce  = 1'b1;
  int g_dep = 4;

  // behavioural model: batch counts and the tracked pair
  int          m_depth, m_wr, m_rd, m_rsp;
  bit          m_bd, m_has_orig, m_has_dup, m_done;
  int          m_oidx, m_didx;
  logic [WW-1:0] m_odata, m_oout, m_dout;

  task automatic model(input bit wen, input bit ren, input logic [WW-1:0] din, input bit vout,
                       input logic [WW-1:0] dout, input bit osel, input bit dsel);
    bit wa, ra, sa, bnd;
    if (g_rst) begin
      m_depth = g_dep; m_wr = 0; m_rd = 0; m_rsp = 0; m_bd = 1'b0;
      m_has_orig = 1'b0; m_has_dup = 1'b0; m_done = 1'b0;
      m_oout = '0; m_dout = '0; m_odata = '0;
    end else begin
      wa  = g_ce && wen  && (m_wr  != m_depth);
      ra  = g_ce && ren  && (m_rd  != m_depth);
      sa  = g_ce && vout && (m_rsp != m_depth);
      bnd = g_ce && (m_depth != 0) && (m_wr + int'(wa) == m_depth) &&
            (m_rd + int'(ra) == m_depth) && (m_rsp + int'(sa) == m_depth);
      if (!m_done) begin
        if (!m_has_orig) begin
          if (wa && osel) begin
            m_has_orig = 1'b1; m_oidx = m_wr; m_odata = din;
            if (sa && m_rsp == m_wr) m_oout = dout;
          end
        end else begin
          if (sa && m_rsp == m_oidx) m_oout = dout;
          if (!m_has_dup && wa && dsel && din == m_odata) begin
            m_has_dup = 1'b1; m_didx = m_wr;
          end
          if (m_has_dup && sa && m_rsp == m_didx) begin
            m_dout = dout; m_done = 1'b1;
          end
        end
        if (bnd && !m_done) begin
          m_has_orig = 1'b0; m_has_dup = 1'b0;
        end
      end
      if (bnd) begin
        m_wr = 0; m_rd = 0; m_rsp = 0; m_depth = g_dep;
      end else begin
        m_wr += int'(wa); m_rd += int'(ra); m_rsp += int'(sa);
      end
      m_bd = bnd;
    end
  endtask

  // one clock cycle: drive, advance model, sample after the edge, compare
  task automatic step(input bit wen, input bit ren, input logic [WW-1:0] din, input bit vout,
                      input logic [WW-1:0] dout, input bit osel, input bit dsel);
    reset            = g_rst;
    mon_if.clk_en    = g_ce;
    mon_if.depth     = PW'(g_dep);
    mon_if.wen_in    = wen;
    mon_if.ren_in    = ren;
    mon_if.data_in   = din;
    mon_if.valid_out = vout;
    mon_if.data_out  = dout;
    mon_if.orig_sel  = osel;
    mon_if.dup_sel   = dsel;
    model(wen, ren, din, vout, dout, osel, dsel);
    @(posedge clk);
    #1;
    check("wen_allow",  32'(mon_if.wen_allow),  32'(m_wr  != m_depth));
    check("ren_allow",  32'(mon_if.ren_allow),  32'(m_rd  != m_depth));
    check("batch_done", 32'(mon_if.batch_done), 32'(m_bd));
    check("qed_done",   32'(mon_if.qed_done),   32'(m_done));
    check("qed_check",  32'(mon_if.qed_check),  32'(!m_done || (m_oout == m_dout)));
  endtask

  task automatic do_reset(input int dep);
    g_dep = dep; g_rst = 1'b1;
    step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    g_rst = 1'b0;
  endtask

  task automatic wr(input logic [WW-1:0] d, input bit osel, input bit dsel);
    step(1'b1, 1'b0, d, 1'b0, '0, osel, dsel);
  endtask

  task automatic rdrsp(input logic [WW-1:0] d);
    step(1'b0, 1'b1, '0, 1'b1, d, 1'b0, 1'b0);
  endtask

  initial begin
    // depth 4: fill, gate, drain, boundary pulse
    do_reset(4);
    check("rst_wen_allow", 32'(mon_if.wen_allow), 32'd1);
    check("rst_qed_check", 32'(mon_if.qed_check), 32'd1);
    for (int i = 0; i < 4; i++) wr(16'(i + 1), 1'b0, 1'b0);
    check("t1_wen_gated", 32'(mon_if.wen_allow), 32'd0);
    wr(16'h00FF, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) rdrsp(16'(i + 1));
    check("t1_batch_done", 32'(mon_if.batch_done), 32'd1);
    check("t1_wen_reopen", 32'(mon_if.wen_allow), 32'd1);
    step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    check("t1_pulse_end", 32'(mon_if.batch_done), 32'd0);

    // depth 3: final write, read and response in one cycle
    do_reset(3);
    for (int i = 0; i < 2; i++) wr(16'(i), 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) rdrsp(16'(i));
    step(1'b1, 1'b1, 16'h0007, 1'b1, 16'h0001, 1'b0, 1'b0);
    check("t2_batch_done", 32'(mon_if.batch_done), 32'd1);
    check("t2_ren_reopen", 32'(mon_if.ren_allow), 32'd1);
    for (int i = 0; i < 3; i++) wr(16'(i), 1'b0, 1'b0);
    check("t2_next_full", 32'(mon_if.wen_allow), 32'd0);

    // matching pair
    do_reset(4);
    wr(16'h0011, 1'b0, 1'b0); wr(16'h00A5, 1'b1, 1'b0);
    wr(16'h0022, 1'b0, 1'b0); wr(16'h00A5, 1'b0, 1'b1);
    rdrsp(16'h0011); rdrsp(16'h00A5); rdrsp(16'h0022); rdrsp(16'h00A5);
    check("t3_qed_done", 32'(mon_if.qed_done), 32'd1);
    check("t3_qed_check", 32'(mon_if.qed_check), 32'd1);

    // mismatching duplicate response
    do_reset(4);
    wr(16'h0011, 1'b0, 1'b0); wr(16'h00A5, 1'b1, 1'b0);
    wr(16'h0022, 1'b0, 1'b0); wr(16'h00A5, 1'b0, 1'b1);
    rdrsp(16'h0011); rdrsp(16'h00A5); rdrsp(16'h0022); rdrsp(16'h005A);
    check("t4_qed_done", 32'(mon_if.qed_done), 32'd1);
    check("t4_qed_check", 32'(mon_if.qed_check), 32'd0);

    // duplicate with different data ignored, pair abandoned at boundary, next batch pairs afresh
    do_reset(4);
    wr(16'h00A5, 1'b1, 1'b0); wr(16'h0011, 1'b0, 1'b1);
    wr(16'h0033, 1'b0, 1'b0); wr(16'h0044, 1'b0, 1'b0);
    rdrsp(16'h00A5); rdrsp(16'h0011); rdrsp(16'h0033); rdrsp(16'h0044);
    check("t5_no_done", 32'(mon_if.qed_done), 32'd0);
    wr(16'h0077, 1'b1, 1'b0); wr(16'h0077, 1'b0, 1'b1);
    wr(16'h0001, 1'b0, 1'b0); wr(16'h0002, 1'b0, 1'b0);
    rdrsp(16'h0077); rdrsp(16'h0077); rdrsp(16'h0001); rdrsp(16'h0002);
    check("t5_next_pair", 32'(mon_if.qed_done), 32'd1);

    // reset in the middle of a pair
    do_reset(4);
    wr(16'h00A5, 1'b1, 1'b0); wr(16'h0000, 1'b0, 1'b0);
    wr(16'h00A5, 1'b0, 1'b1); wr(16'h0000, 1'b0, 1'b0);
    rdrsp(16'h00A5);
    do_reset(4);
    check("t6_wen_allow", 32'(mon_if.wen_allow), 32'd1);
    check("t6_ren_allow", 32'(mon_if.ren_allow), 32'd1);
    check("t6_batch_done", 32'(mon_if.batch_done), 32'd0);
    check("t6_qed_done", 32'(mon_if.qed_done), 32'd0);
    check("t6_qed_check", 32'(mon_if.qed_check), 32'd1);
    wr(16'h003C, 1'b1, 1'b0); wr(16'h003C, 1'b0, 1'b1);
    wr(16'h0005, 1'b0, 1'b0); wr(16'h0006, 1'b0, 1'b0);
    rdrsp(16'h003C); rdrsp(16'h00C3); rdrsp(16'h0005); rdrsp(16'h0006);
    check("t6_fresh_done", 32'(mon_if.qed_done), 32'd1);
    check("t6_fresh_check", 32'(mon_if.qed_check), 32'd0);

    // random traffic against the model
    do_reset(3);
    for (int n = 0; n < 3000; n++) begin
      g_rst = ($urandom_range(0, 249) == 0);
      g_ce  = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 29) == 0) g_dep = int'($urandom_range(0, 5));
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 16'($urandom_range(0, 3)),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0));
    end
    g_rst = 1'b0;
    g_ce  = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
